mu0_seq_decoder: RTL and testbench

- Parametrised successor to the MU0 instruction decoder.
- Owns the FETCH/EXEC1/EXEC2 phase sequencer internally instead of receiving phase strobes, and generalises the datapath width.
- Adds multi-cycle barrel-free LSL/LSR: one bit per cycle, amount taken from the operand field.
- Adds a sticky halt state for STP and illegal-opcode flagging. Sits between the IR/ACC registers and the PC counter, memory, ACC and mux selects of the CPU datapath.

---
 rtl/mu0_pkg.sv | 27 ++
 rtl/mu0_op_decode.sv | 25 ++
 rtl/mu0_seq_decoder.sv | 162 ++++++++++++++++
 tb/tb_mu0_seq_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared opcode and sequencer-state definitions for the MU0 decoder family.
package mu0_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned NUM_OPS = 2 ** OP_W;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_STA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_JMI = 4'h5;
  localparam logic [OP_W-1:0] OP_JEQ = 4'h6;
  localparam logic [OP_W-1:0] OP_STP = 4'h7;
  localparam logic [OP_W-1:0] OP_LDI = 4'h8;
  localparam logic [OP_W-1:0] OP_LSL = 4'h9;
  localparam logic [OP_W-1:0] OP_LSR = 4'hA;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/mu0_op_decode.sv
// Combinational one-hot opcode decode plus accumulator EQ/MI flags.
module mu0_op_decode
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [DATA_W-1:0]  acc_i,
  output logic [NUM_OPS-1:0] op_o,
  output logic               eq_o,
  output logic               mi_o,
  output logic               illegal_o
);

  always_comb begin
    op_o           = '0;
    op_o[opcode_i] = 1'b1;
  end

  assign eq_o      = (acc_i == '0);
  assign mi_o      = acc_i[DATA_W-1];
  // Everything above LSR is unassigned.
  assign illegal_o = (opcode_i > OP_LSR);

endmodule

// File: rtl/mu0_seq_decoder.sv
// MU0 decoder with internal FETCH/EXEC1/EXEC2 sequencer, bit-serial shifts and sticky halt.
module mu0_seq_decoder
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] ACC_OUT,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              SHIFTING,
  output logic              HALTED,
  output logic              IR_LOAD,
  output logic              EXTRA,
  output logic              MUX1,
  output logic              MUX3,
  output logic              SLOAD,
  output logic              CNT_EN,
  output logic              WREN,
  output logic              SLOAD_ACC,
  output logic              SHIFT,
  output logic              ENABLE_ACC,
  output logic              ADD_SUB,
  output logic              MUX4,
  output logic              ILLEGAL
);

  state_e               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]      opcode;
  logic [SHAMT_W-1:0]   amt;
  logic [NUM_OPS-1:0]   op;
  logic                 eq, mi, illegal;
  logic                 is_lda, is_sta, is_add, is_sub, is_jmp, is_jmi, is_jeq;
  logic                 is_stp, is_ldi, is_lsl, is_lsr;
  logic                 take_jump, shift_zero;

  assign opcode = IR[DATA_W-1 -: OP_W];
  assign amt    = IR[SHAMT_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{IR[DATA_W-OP_W-1:SHAMT_W], op[NUM_OPS-1:11]};

  mu0_op_decode #(
    .DATA_W (DATA_W)
  ) u_op_decode (
    .opcode_i  (opcode),
    .acc_i     (ACC_OUT),
    .op_o      (op),
    .eq_o      (eq),
    .mi_o      (mi),
    .illegal_o (illegal)
  );

  assign is_lda = op[OP_LDA];
  assign is_sta = op[OP_STA];
  assign is_add = op[OP_ADD];
  assign is_sub = op[OP_SUB];
  assign is_jmp = op[OP_JMP];
  assign is_jmi = op[OP_JMI];
  assign is_jeq = op[OP_JEQ];
  assign is_stp = op[OP_STP];
  assign is_ldi = op[OP_LDI];
  assign is_lsl = op[OP_LSL];
  assign is_lsr = op[OP_LSR];

  assign take_jump  = is_jmp | (is_jmi & mi) | (is_jeq & eq);
  assign shift_zero = (is_lsl | is_lsr) & (amt == '0);

  assign FETCH    = (state_q == ST_FETCH);
  assign EXEC1    = (state_q == ST_EXEC1);
  assign EXEC2    = (state_q == ST_EXEC2);
  assign SHIFTING = (state_q == ST_SHIFT);
  assign HALTED   = (state_q == ST_HALT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    IR_LOAD    = 1'b0;
    EXTRA      = 1'b0;
    MUX1       = 1'b0;
    MUX3       = 1'b0;
    SLOAD      = 1'b0;
    CNT_EN     = 1'b0;
    WREN       = 1'b0;
    SLOAD_ACC  = 1'b0;
    SHIFT      = 1'b0;
    ENABLE_ACC = 1'b0;
    ADD_SUB    = 1'b0;
    MUX4       = 1'b0;
    ILLEGAL    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        IR_LOAD = 1'b1;
        state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        EXTRA      = is_lda | is_add | is_sub;
        MUX1       = is_sta | is_lda | is_add | is_sub | take_jump;
        MUX3       = is_lda | is_ldi | is_add | is_sub;
        SLOAD      = take_jump;
        WREN       = is_sta;
        SLOAD_ACC  = is_ldi;
        ENABLE_ACC = is_ldi;
        CNT_EN     = is_ldi | is_sta | (is_jmi & ~mi) | (is_jeq & ~eq) | illegal | shift_zero;
        ADD_SUB    = is_add;
        ILLEGAL    = illegal;
        if (is_lda || is_add || is_sub) begin
          state_d = ST_EXEC2;
        end else if ((is_lsl || is_lsr) && !shift_zero) begin
          state_d = ST_SHIFT;
          cnt_d   = amt;
        end else if (is_stp) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC2: begin
        MUX1       = 1'b1;
        SLOAD_ACC  = 1'b1;
        ENABLE_ACC = 1'b1;
        CNT_EN     = 1'b1;
        MUX3       = is_lda;
        ADD_SUB    = is_add;
        state_d    = ST_FETCH;
      end
      ST_SHIFT: begin
        SHIFT      = 1'b1;
        ENABLE_ACC = 1'b1;
        MUX4       = is_lsr;
        cnt_d      = cnt_q - SHAMT_W'(1);
        // <=1 rather than ==1 so a corrupted zero count cannot wrap into a long shift.
        if (cnt_q <= SHAMT_W'(1)) begin
          CNT_EN  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mu0_seq_decoder.sv
// Directed bench for mu0_seq_decoder: per-cycle control vectors against hand-derived values.
module tb_mu0_seq_decoder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] IR;
  logic [15:0] ACC_OUT;
  logic FETCH, EXEC1, EXEC2, SHIFTING, HALTED, IR_LOAD, EXTRA, MUX1, MUX3, SLOAD;
  logic CNT_EN, WREN, SLOAD_ACC, SHIFT, ENABLE_ACC, ADD_SUB, MUX4, ILLEGAL;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  localparam logic [17:0] B_FETCH = 18'h1 << 17;
  localparam logic [17:0] B_EXEC1 = 18'h1 << 16;
  localparam logic [17:0] B_EXEC2 = 18'h1 << 15;
  localparam logic [17:0] B_SHFTG = 18'h1 << 14;
  localparam logic [17:0] B_HALTD = 18'h1 << 13;
  localparam logic [17:0] B_IRLD  = 18'h1 << 12;
  localparam logic [17:0] B_EXTRA = 18'h1 << 11;
  localparam logic [17:0] B_MUX1  = 18'h1 << 10;
  localparam logic [17:0] B_MUX3  = 18'h1 << 9;
  localparam logic [17:0] B_SLOAD = 18'h1 << 8;
  localparam logic [17:0] B_CNT   = 18'h1 << 7;
  localparam logic [17:0] B_WREN  = 18'h1 << 6;
  localparam logic [17:0] B_SLACC = 18'h1 << 5;
  localparam logic [17:0] B_SHIFT = 18'h1 << 4;
  localparam logic [17:0] B_ENACC = 18'h1 << 3;
  localparam logic [17:0] B_ADDSB = 18'h1 << 2;
  localparam logic [17:0] B_MUX4  = 18'h1 << 1;
  localparam logic [17:0] B_ILL   = 18'h1;

  localparam logic [17:0] V_FETCH = B_FETCH | B_IRLD;
  localparam logic [17:0] V_SHL   = B_SHFTG | B_SHIFT | B_ENACC;
  localparam logic [17:0] V_SHR   = V_SHL | B_MUX4;

  mu0_seq_decoder #(
    .DATA_W  (16),
    .SHAMT_W (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IR         (IR),
    .ACC_OUT    (ACC_OUT),
    .FETCH      (FETCH),
    .EXEC1      (EXEC1),
    .EXEC2      (EXEC2),
    .SHIFTING   (SHIFTING),
    .HALTED     (HALTED),
    .IR_LOAD    (IR_LOAD),
    .EXTRA      (EXTRA),
    .MUX1       (MUX1),
    .MUX3       (MUX3),
    .SLOAD      (SLOAD),
    .CNT_EN     (CNT_EN),
    .WREN       (WREN),
    .SLOAD_ACC  (SLOAD_ACC),
    .SHIFT      (SHIFT),
    .ENABLE_ACC (ENABLE_ACC),
    .ADD_SUB    (ADD_SUB),
    .MUX4       (MUX4),
    .ILLEGAL    (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  logic [17:0] ctrl;
  assign ctrl = {FETCH, EXEC1, EXEC2, SHIFTING, HALTED, IR_LOAD, EXTRA, MUX1, MUX3, SLOAD,
                 CNT_EN, WREN, SLOAD_ACC, SHIFT, ENABLE_ACC, ADD_SUB, MUX4, ILLEGAL};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Advance one clock, then sample the decoded controls away from the edge.
  task automatic step_check(input string tag, input logic [17:0] exp);
    @(posedge CLK);
    #1;
    check(tag, ctrl, exp);
  endtask

  initial begin
    RESET   = 1'b1;
    IR      = 16'h0010;
    ACC_OUT = 16'h1234;
    @(posedge CLK);
    step_check("reset_hold", V_FETCH);
    RESET = 1'b0;

    // LDA: 3-cycle instruction
    step_check("lda_exec1", B_EXEC1 | B_EXTRA | B_MUX1 | B_MUX3);
    step_check("lda_exec2", B_EXEC2 | B_MUX1 | B_SLACC | B_ENACC | B_CNT | B_MUX3);
    step_check("lda_fetch", V_FETCH);

    // JEQ taken / not taken
    IR = 16'h6020; ACC_OUT = 16'h0000;
    step_check("jeq_taken", B_EXEC1 | B_MUX1 | B_SLOAD);
    step_check("jeq_t_fetch", V_FETCH);
    ACC_OUT = 16'h0001;
    step_check("jeq_not", B_EXEC1 | B_CNT);
    step_check("jeq_n_fetch", V_FETCH);

    // JMI taken / not taken
    IR = 16'h5000; ACC_OUT = 16'h8000;
    step_check("jmi_taken", B_EXEC1 | B_MUX1 | B_SLOAD);
    step_check("jmi_t_fetch", V_FETCH);
    ACC_OUT = 16'h7FFF;
    step_check("jmi_not", B_EXEC1 | B_CNT);
    step_check("jmi_n_fetch", V_FETCH);

    // ADD, SUB, STA, JMP, LDI
    IR = 16'h2005;
    step_check("add_exec1", B_EXEC1 | B_EXTRA | B_MUX1 | B_MUX3 | B_ADDSB);
    step_check("add_exec2", B_EXEC2 | B_MUX1 | B_SLACC | B_ENACC | B_CNT | B_ADDSB);
    step_check("add_fetch", V_FETCH);
    IR = 16'h3005;
    step_check("sub_exec1", B_EXEC1 | B_EXTRA | B_MUX1 | B_MUX3);
    step_check("sub_exec2", B_EXEC2 | B_MUX1 | B_SLACC | B_ENACC | B_CNT);
    step_check("sub_fetch", V_FETCH);
    IR = 16'h1040;
    step_check("sta_exec1", B_EXEC1 | B_MUX1 | B_WREN | B_CNT);
    step_check("sta_fetch", V_FETCH);
    IR = 16'h4040; ACC_OUT = 16'h0001;
    step_check("jmp_exec1", B_EXEC1 | B_MUX1 | B_SLOAD);
    step_check("jmp_fetch", V_FETCH);
    IR = 16'h80FF;
    step_check("ldi_exec1", B_EXEC1 | B_MUX3 | B_SLACC | B_ENACC | B_CNT);
    step_check("ldi_fetch", V_FETCH);

    // LSR 3: exactly three shift cycles, CNT_EN only on the last
    IR = 16'hA003;
    step_check("lsr3_exec1", B_EXEC1);
    step_check("lsr3_sh1", V_SHR);
    step_check("lsr3_sh2", V_SHR);
    step_check("lsr3_sh3", V_SHR | B_CNT);
    step_check("lsr3_fetch", V_FETCH);

    // LSL 0: no shift cycle
    IR = 16'h9000;
    step_check("lsl0_exec1", B_EXEC1 | B_CNT);
    step_check("lsl0_fetch", V_FETCH);

    // LSL 2: left direction
    IR = 16'h9002;
    step_check("lsl2_exec1", B_EXEC1);
    step_check("lsl2_sh1", V_SHL);
    step_check("lsl2_sh2", V_SHL | B_CNT);
    step_check("lsl2_fetch", V_FETCH);

    // Illegal opcode
    IR = 16'hC000;
    step_check("ill_exec1", B_EXEC1 | B_CNT | B_ILL);
    step_check("ill_fetch", V_FETCH);

    // LSR 15 interrupted by reset on the fifth shift cycle
    IR = 16'hA00F;
    step_check("lsr15_exec1", B_EXEC1);
    for (int i = 1; i <= 5; i++) step_check($sformatf("lsr15_sh%0d", i), V_SHR);
    RESET = 1'b1;
    step_check("lsr15_reset", V_FETCH);
    RESET = 1'b0;

    // STP: sticky halt with all controls low, left only by reset
    IR = 16'h7000;
    step_check("stp_exec1", B_EXEC1);
    for (int i = 0; i < 20; i++) step_check($sformatf("halt_%0d", i), B_HALTD);
    RESET = 1'b1;
    step_check("halt_reset", V_FETCH);
    RESET = 1'b0;
    IR = 16'h8001;
    step_check("post_halt_ldi", B_EXEC1 | B_MUX3 | B_SLACC | B_ENACC | B_CNT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
